// File: rtl/led_scan_pkg.sv
// Shared types, constants and the BCD-to-segment decoder for the LED matrix / 7-seg scan scheduler.
package led_scan_pkg;

  localparam int ROWS      = 8;
  localparam int DIGITS    = 4;
  localparam int BLANK_CYC = 16;

  typedef logic [2:0] row_t;
  typedef logic [7:0] plane_t;
  typedef logic [1:0] digit_t;

  typedef enum logic {IDLE, PEND} swap_state_t;

  typedef struct packed {
    plane_t red;
    plane_t green;
    plane_t blue;
  } pixel_row_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] COM_OFF = 4'b1111;

  // Common-anode {a,b,c,d,e,f,g}; codes above 9 blank the digit
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = 7'b0000001;
      4'd1:    code = 7'b1001111;
      4'd2:    code = 7'b0010010;
      4'd3:    code = 7'b0000110;
      4'd4:    code = 7'b1001100;
      4'd5:    code = 7'b0100100;
      4'd6:    code = 7'b0100000;
      4'd7:    code = 7'b0001111;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0000100;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/led_scan_scheduler_if.sv
// Back-buffer write port and frame-swap handshake between game logic (master) and the scan scheduler (slave).
interface led_scan_scheduler_if;
  import led_scan_pkg::*;

  logic   wr_en;
  row_t   wr_row;
  plane_t wr_red;
  plane_t wr_green;
  plane_t wr_blue;
  logic   swap_req;
  logic   swap_ack;

  modport master (
    output wr_en, wr_row, wr_red, wr_green, wr_blue, swap_req,
    input  swap_ack
  );

  modport slave (
    input  wr_en, wr_row, wr_red, wr_green, wr_blue, swap_req,
    output swap_ack
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Scan-slot prescaler: counts 0..TICK_DIV-1 and flags the last count of each slot.
module scan_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic srst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scan_scheduler.sv
// Double-buffered 8x8 RGB row scan plus 4-digit 7-seg multiplex, swapping buffers only at frame wrap.
// Optional LED_SCAN_BLANKING_EN blanks the colour lines for the first BLANK_CYC cycles of each row slot.
module led_scan_scheduler
  import led_scan_pkg::*;
#(
  parameter int TICK_DIV = 25000
) (
  input  logic                 CLK,
  input  logic                 reset,
  led_scan_scheduler_if.slave  bus,
  input  logic [15:0]          digit_val,
  output logic                 frame_tick,
  output logic [0:27]          led,
  output logic [3:0]           COM,
  output logic [6:0]           seg
);

  logic        tick;
  logic        wrap;
  logic        swap_now;
  logic        back_sel;
  logic        blank;

  row_t        row_q, row_d;
  digit_t      digit_q, digit_d;
  logic        sel_q, sel_d;
  swap_state_t state_q, state_d;

  pixel_row_t  buf_q [2][ROWS];
  pixel_row_t  wr_row_data;
  pixel_row_t  disp_d;
  logic [ROWS-1:0] row_we;

  logic [0:27] led_q, led_d;
  logic [3:0]  com_q, com_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_tick_q;
  logic        swap_ack_q;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (CLK),
    .srst (reset),
    .tick (tick)
  );

  assign wrap        = tick && (row_q == row_t'(ROWS - 1));
  assign swap_now    = (state_q == PEND) && bus.swap_req && wrap;
  assign back_sel    = ~sel_q;
  assign wr_row_data = {bus.wr_red, bus.wr_green, bus.wr_blue};

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_we
      assign row_we[gi] = bus.wr_en && (bus.wr_row == row_t'(gi));
    end
  endgenerate

  always_comb begin
    row_d   = row_q;
    digit_d = digit_q;
    if (tick) begin
      row_d   = (row_q == row_t'(ROWS - 1)) ? '0 : row_q + row_t'(1);
      digit_d = (digit_q == digit_t'(DIGITS - 1)) ? '0 : digit_q + digit_t'(1);
    end
    sel_d   = swap_now ? ~sel_q : sel_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.swap_req) state_d = PEND;
      PEND: if (!bus.swap_req || wrap) state_d = IDLE;
    endcase
  end

`ifdef LED_SCAN_BLANKING_EN
  localparam int BW = $clog2(BLANK_CYC + 1);

  logic [BW-1:0] blank_pos_q, blank_pos_d;

  // Saturating position within the row slot; 0 on the first cycle the new row is shown
  always_comb begin
    blank_pos_d = blank_pos_q;
    if (tick) begin
      blank_pos_d = '0;
    end else if (blank_pos_q != BW'(BLANK_CYC)) begin
      blank_pos_d = blank_pos_q + BW'(1);
    end
  end

  assign blank = (blank_pos_d < BW'(BLANK_CYC));

  always_ff @(posedge CLK) begin
    if (reset) begin
      blank_pos_q <= '0;
    end else begin
      blank_pos_q <= blank_pos_d;
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Outputs are built from next-cycle state; a write landing in the buffer that becomes
  // front at this very edge is forwarded so row 0 of the new frame is never stale.
  always_comb begin
    disp_d = buf_q[sel_d][row_d];
    if (swap_now && row_we[row_d]) begin
      disp_d = wr_row_data;
    end
    led_d = '1;
    if (!blank) begin
      led_d[0:7]   = ~disp_d.red;
      led_d[8:15]  = ~disp_d.green;
      led_d[16:23] = ~disp_d.blue;
    end
    led_d[24:26] = row_d;
    led_d[27]    = 1'b1;
    com_d        = ~(4'b0001 << digit_d);
    seg_d        = bcd_to_seg(digit_val[{digit_d, 2'b00} +: 4]);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      row_q        <= '0;
      digit_q      <= '0;
      sel_q        <= 1'b0;
      state_q      <= IDLE;
      led_q        <= {24'hFF_FFFF, 3'b000, 1'b1};
      com_q        <= COM_OFF;
      seg_q        <= SEG_OFF;
      frame_tick_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else begin
      row_q        <= row_d;
      digit_q      <= digit_d;
      sel_q        <= sel_d;
      state_q      <= state_d;
      led_q        <= led_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
      frame_tick_q <= wrap;
      swap_ack_q   <= swap_now;
      for (int r = 0; r < ROWS; r++) begin
        if (row_we[r]) begin
          buf_q[back_sel][r] <= wr_row_data;
        end
      end
    end
  end

  assign led          = led_q;
  assign COM          = com_q;
  assign seg          = seg_q;
  assign frame_tick   = frame_tick_q;
  assign bus.swap_ack = swap_ack_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Self-checking bench for led_scan_scheduler: cycle-indexed reference model plus directed checkpoints.
module tb_led_scan_scheduler;
  import led_scan_pkg::*;

  localparam int TICK_DIV = 20;
  localparam int FRAME    = TICK_DIV * 8;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] digit_val;
  logic        frame_tick;
  logic [0:27] led;
  logic [3:0]  COM;
  logic [6:0]  seg;

  led_scan_scheduler_if bus();

  led_scan_scheduler #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .bus        (bus),
    .digit_val  (digit_val),
    .frame_tick (frame_tick),
    .led        (led),
    .COM        (COM),
    .seg        (seg)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          fails  = 0;
  int          t      = 0;
  logic [23:0] front_m [8];
  logic [23:0] back_m  [8];
  logic        req_prev = 1'b0;
  logic        last_swap = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, got, exp);
    end
  endtask

  // One clock: sample driven inputs, advance the model, compare every output.
  task automatic step();
    logic        s_rst, s_we, s_req;
    logic [2:0]  s_row;
    logic [23:0] s_data;
    logic [15:0] s_dv;
    logic [23:0] tmp;
    logic [0:27] e_led;
    logic [3:0]  e_com;
    logic [6:0]  e_seg;
    logic        e_ft, e_ack;
    int          row, dig;
    s_rst  = reset;
    s_we   = bus.wr_en;
    s_req  = bus.swap_req;
    s_row  = bus.wr_row;
    s_data = {bus.wr_red, bus.wr_green, bus.wr_blue};
    s_dv   = digit_val;
    @(posedge CLK);
    #1;
    if (s_rst) begin
      t = 0;
      for (int i = 0; i < 8; i++) begin
        front_m[i] = '0;
        back_m[i]  = '0;
      end
      req_prev  = 1'b0;
      last_swap = 1'b0;
      e_led = {24'hFFFFFF, 3'b000, 1'b1};
      e_com = 4'b1111;
      e_seg = 7'b1111111;
      e_ft  = 1'b0;
      e_ack = 1'b0;
    end else begin
      t++;
      if (s_we) back_m[s_row] = s_data;
      // A request is honoured at the wrap if it was seen at this edge and the one before
      last_swap = ((t % FRAME) == 0) && s_req && req_prev;
      if (last_swap) begin
        for (int i = 0; i < 8; i++) begin
          tmp        = front_m[i];
          front_m[i] = back_m[i];
          back_m[i]  = tmp;
        end
      end
      req_prev = s_req;
      row = (t / TICK_DIV) % 8;
      dig = (t / TICK_DIV) % 4;
      e_led[0:7]   = ~front_m[row][23:16];
      e_led[8:15]  = ~front_m[row][15:8];
      e_led[16:23] = ~front_m[row][7:0];
`ifdef LED_SCAN_BLANKING_EN
      if ((t % TICK_DIV) < 16) e_led[0:23] = '1;
`endif
      e_led[24:26] = 3'(row);
      e_led[27]    = 1'b1;
      e_com = 4'b1111 ^ (4'b0001 << dig);
      e_seg = ref_seg(4'(s_dv >> (4 * dig)));
      e_ft  = ((t % FRAME) == 0);
      e_ack = last_swap;
    end
    chk("led",        {4'b0, led},           {4'b0, e_led});
    chk("COM",        {28'b0, COM},          {28'b0, e_com});
    chk("seg",        {25'b0, seg},          {25'b0, e_seg});
    chk("frame_tick", {31'b0, frame_tick},   {31'b0, e_ft});
    chk("swap_ack",   {31'b0, bus.swap_ack}, {31'b0, e_ack});
    if (e_ack) $display("swap ack at t=%0d", t);
  endtask

  initial begin
    int ack_t;
    int acks;
    logic got;
    logic [7:0] blank_exp;

    reset = 1'b1;
    digit_val = '0;
    bus.wr_en = 1'b0; bus.wr_row = '0;
    bus.wr_red = '0; bus.wr_green = '0; bus.wr_blue = '0;
    bus.swap_req = 1'b0;
    step();
    step();
    chk("rst_led",  {4'b0, led}, {4'b0, 24'hFFFFFF, 3'b000, 1'b1});
    chk("rst_COM",  {28'b0, COM}, 32'hF);
    chk("rst_seg",  {25'b0, seg}, 32'h7F);
    $display("reset held 2 cycles");
    reset = 1'b0;

    // Row 2 red 0x81, then hold swap request through the first wrap
    bus.wr_en = 1'b1; bus.wr_row = 3'd2; bus.wr_red = 8'h81;
    step();
    $display("wr row=2 red=81 t=%0d", t);
    bus.wr_en = 1'b0; bus.wr_red = 8'h00;
    bus.swap_req = 1'b1;
    ack_t = -1;
    for (int i = 0; i < 2 * FRAME && ack_t < 0; i++) begin
      step();
      if (bus.swap_ack === 1'b1) ack_t = t;
    end
    chk("swap_ack_cycle", ack_t, FRAME);
    bus.swap_req = 1'b0;
    while (t < FRAME + 45) step();
    chk("row2_red", {24'b0, led[0:7]}, 32'h7E);
    chk("row2_idx", {29'b0, led[24:26]}, 32'd2);

    // Row 3 green without a swap stays invisible for two frames
    bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_green = 8'hFF;
    step();
    $display("wr row=3 green=FF t=%0d", t);
    bus.wr_en = 1'b0; bus.wr_green = 8'h00;
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.swap_ack === 1'b1) acks++;
      if ((t % FRAME) == 70) chk("row3_green", {24'b0, led[8:15]}, 32'hFF);
    end
    chk("no_ack_no_req", acks, 0);

    // Row 4 red 0xFF swapped in, then probe early and late in its slot
    bus.wr_en = 1'b1; bus.wr_row = 3'd4; bus.wr_red = 8'hFF;
    step();
    $display("wr row=4 red=FF t=%0d", t);
    bus.wr_en = 1'b0; bus.wr_red = 8'h00;
    bus.swap_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      step();
      if (bus.swap_ack === 1'b1) got = 1'b1;
    end
    chk("row4_swap_ack", {31'b0, got}, 32'd1);
    bus.swap_req = 1'b0;
`ifdef LED_SCAN_BLANKING_EN
    blank_exp = 8'hFF;
`else
    blank_exp = 8'h00;
`endif
    while ((t % FRAME) != 83) step();
    chk("row4_early", {24'b0, led[0:7]}, {24'b0, blank_exp});
    while ((t % FRAME) != 97) step();
    chk("row4_late", {24'b0, led[0:7]}, 32'h00);

    // Digit multiplex
    digit_val = 16'h0942;
    $display("digit_val=0942 t=%0d", t);
    for (int i = 0; i < 4 * TICK_DIV + 5; i++) begin
      step();
      case (COM)
        4'b1110: chk("dig0", {25'b0, seg}, 32'b0010010);
        4'b1101: chk("dig1", {25'b0, seg}, 32'b1001100);
        4'b1011: chk("dig2", {25'b0, seg}, 32'b0000100);
        4'b0111: chk("dig3", {25'b0, seg}, 32'b0000001);
        default: chk("com_onehot", {28'b0, COM}, 32'hE);
      endcase
    end
    digit_val = 16'h000A;
    $display("digit_val=000A t=%0d", t);
    got = 1'b0;
    for (int i = 0; i < 5 * TICK_DIV && !got; i++) begin
      step();
      if (COM == 4'b1110) begin
        chk("dig0_blank", {25'b0, seg}, 32'h7F);
        got = 1'b1;
      end
    end
    chk("dig0_seen", {31'b0, got}, 32'd1);

    // Randomised writes, requests and digit values against the model
    for (int i = 0; i < 1000; i++) begin
      bus.wr_en    = ($urandom_range(3) == 0);
      bus.wr_row   = 3'($urandom_range(7));
      bus.wr_red   = 8'($urandom);
      bus.wr_green = 8'($urandom);
      bus.wr_blue  = 8'($urandom);
      if ($urandom_range(39) == 0) bus.swap_req = ~bus.swap_req;
      if ($urandom_range(29) == 0) digit_val = 16'($urandom);
      if (bus.wr_en)
        $display("wr row=%0d rgb=%h%h%h req=%0b t=%0d",
                 bus.wr_row, bus.wr_red, bus.wr_green, bus.wr_blue, bus.swap_req, t);
      step();
    end
    bus.wr_en = 1'b0;

    // Reset mid-frame at row 5 with a request pending
    bus.swap_req = 1'b1;
    while ((t % FRAME) != 105) step();
    reset = 1'b1;
    bus.swap_req = 1'b0;
    step();
    $display("mid-frame reset");
    chk("midrst_COM", {28'b0, COM}, 32'hF);
    chk("midrst_row", {29'b0, led[24:26]}, 32'd0);
    chk("midrst_ack", {31'b0, bus.swap_ack}, 32'd0);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < FRAME + 40; i++) begin
      step();
      if (bus.swap_ack === 1'b1) acks++;
    end
    chk("no_ack_after_reset", acks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
